// File: rtl/uart_core.sv
// Full-duplex UART: runtime parity/stop configuration, ready/valid FIFO channels,
// mid-bit rx sampling with start-bit glitch rejection and per-word error flags.

module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module uart_core #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  input  logic                 clr_err,
  input  logic [DIV_WIDTH-1:0] baud_tick_max,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  output logic                 tx_busy
);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t tx_state, tx_next;

  logic [DATA_BITS-1:0] txf_dout, tx_shift;
  logic                 txf_empty, txf_full, txf_pop;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_n;
  logic [BW-1:0]        tx_idx;
  logic                 tx_stop_idx, tx_par_en, tx_stop2, tx_par_bit;
  logic                 tx_tick, tx_bit, tx_q;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_valid && tx_ready), .din(tx_data),
    .pop(txf_pop), .dout(txf_dout), .empty(txf_empty), .full(txf_full)
  );

  assign tx_ready = !txf_full;
  assign tx_busy  = (tx_state != TX_IDLE);
  assign tx_tick  = (tx_cnt == tx_n);
  assign tx       = tx_q;

  always_comb begin
    tx_next = tx_state;
    txf_pop = 1'b0;
    tx_bit  = 1'b1;
    case (tx_state)
      TX_IDLE:   if (!txf_empty) begin txf_pop = 1'b1; tx_next = TX_START; end
      TX_START:  begin tx_bit = 1'b0; if (tx_tick) tx_next = TX_DATA; end
      TX_DATA: begin
        tx_bit = tx_shift[0];
        if (tx_tick && tx_idx == LAST_BIT) tx_next = tx_par_en ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin tx_bit = tx_par_bit; if (tx_tick) tx_next = TX_STOP; end
      TX_STOP:   if (tx_tick && tx_stop_idx == tx_stop2) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  // tx is registered, so the line lags the state by one clock throughout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_q     <= tx_bit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift    <= '0;
      tx_par_bit  <= 1'b0;
      tx_n        <= '0;
      tx_par_en   <= 1'b0;
      tx_stop2    <= 1'b0;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
    end else if (txf_pop) begin
      tx_shift    <= txf_dout;
      tx_par_bit  <= (^txf_dout) ^ parity_odd;
      tx_n        <= baud_tick_max;
      tx_par_en   <= parity_en;
      tx_stop2    <= stop2;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
    end else if (tx_state != TX_IDLE) begin
      if (tx_tick) begin
        tx_cnt <= '0;
        if (tx_state == TX_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_idx   <= tx_idx + 1'b1;
        end
        if (tx_state == TX_STOP) tx_stop_idx <= 1'b1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  rx_state_t rx_state, rx_next;

  logic                 rx_s1, rx_s2;
  logic [DIV_WIDTH-1:0] rx_cnt, rx_n;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_en, rx_par_odd, rx_par_err;
  logic                 rx_tick, rx_half, rx_push;
  logic [DATA_BITS+1:0] rxf_dout;
  logic                 rxf_empty, rxf_full;

  assign rx_tick = (rx_cnt == rx_n);
  assign rx_half = (rx_cnt == (rx_n >> 1));

  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    case (rx_state)
      RX_IDLE:      if (!rx_s2) rx_next = RX_START;
      RX_START:     if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_tick && rx_idx == LAST_BIT) rx_next = rx_par_en ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (rx_tick) rx_next = RX_STOP;
      RX_STOP: if (rx_tick) begin
        rx_push = 1'b1;
        rx_next = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_s2) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_state <= rx_next;
    end
  end

  // Config is re-latched every idle cycle, so the value at the start bit is what sticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt     <= '0;
      rx_n       <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_err <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt     <= '0;
          rx_idx     <= '0;
          rx_par_err <= 1'b0;
          rx_n       <= baud_tick_max;
          rx_par_en  <= parity_en;
          rx_par_odd <= parity_odd;
        end
        RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
        RX_DATA, RX_PARITY, RX_STOP: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_state == RX_DATA) begin
              rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
              rx_idx   <= rx_idx + 1'b1;
            end
            if (rx_state == RX_PARITY) rx_par_err <= rx_s2 ^ (^rx_shift) ^ rx_par_odd;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  uart_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .din({rx_par_err, !rx_s2, rx_shift}),
    .pop(rx_ready), .dout(rxf_dout), .empty(rxf_empty), .full(rxf_full)
  );

  assign rx_valid      = !rxf_empty;
  assign rx_data       = rx_valid ? rxf_dout[DATA_BITS-1:0] : '0;
  assign rx_frame_err  = rx_valid && rxf_dout[DATA_BITS];
  assign rx_parity_err = rx_valid && rxf_dout[DATA_BITS+1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                                rx_overrun <= 1'b0;
    else if (rx_push && rxf_full && !(rx_ready && rx_valid))   rx_overrun <= 1'b1;
    else if (clr_err)                                          rx_overrun <= 1'b0;
  end
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: tx bit timing, loopback, overrun, frame/parity error,
// glitch rejection and mid-frame reset, with an rx-word scoreboard.

module tb_uart_core;
  localparam int unsigned DB = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned DW = 14;

  logic          clk = 1'b0;
  logic          reset, rx, tx, tx_valid, tx_ready, rx_valid, rx_ready;
  logic          rx_frame_err, rx_parity_err, rx_overrun, clr_err;
  logic          parity_en, parity_odd, stop2, tx_busy;
  logic [DB-1:0] tx_data, rx_data;
  logic [DW-1:0] baud_tick_max;
  logic          loop, rx_drv;

  int errors = 0;
  int checks = 0;
  logic [DB+1:0] exp_q[$];

  always #5 clk = ~clk;
  assign rx = loop ? tx : rx_drv;

  uart_core #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .DIV_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun), .clr_err(clr_err),
    .baud_tick_max(baud_tick_max), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .tx_busy(tx_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted rx word must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("rx_extra_word", exp_q.size(), 1);
      else check("rx_word", {rx_parity_err, rx_frame_err, rx_data}, exp_q.pop_front());
    end
  end

  task automatic send_rx(input logic [7:0] d, input logic bad_par, input logic stopv, input int n);
    rx_drv = 1'b0;
    repeat (n + 1) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (n + 1) @(posedge clk);
    end
    if (parity_en) begin
      rx_drv = (^d) ^ parity_odd ^ bad_par;
      repeat (n + 1) @(posedge clk);
    end
    rx_drv = stopv;
    repeat (n + 1) @(posedge clk);
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      @(posedge clk);
      c++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic count_run(input logic level, output int n);
    n = 0;
    while (tx_busy == level && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    logic [9:0]    frame;
    logic [DB-1:0] d;
    logic [DB-1:0] words [3];
    int            run, lo1, hi, lo2;
    logic          saw_low;

    reset = 1'b0; loop = 1'b0; rx_drv = 1'b1; tx_valid = 1'b0; tx_data = '0;
    rx_ready = 1'b1; clr_err = 1'b0; baud_tick_max = 14'd9;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", rx_frame_err, 0);
    check("rst_parity_err", rx_parity_err, 0);
    check("rst_overrun", rx_overrun, 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);

    // 8N1, N=9, single word 0xA5
    @(negedge clk);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(posedge clk);
    #1 check("tx_latency_high", tx, 1);
    @(posedge clk);
    #1;
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check("tx_bit_first", tx, frame[k]);
      repeat (9) @(posedge clk);
      #1 check("tx_bit_last", tx, frame[k]);
      @(posedge clk);
      #1;
    end
    check("tx_busy_done", tx_busy, 0);
    check("tx_idle_done", tx, 1);

    // Loopback, N=15, odd parity, two stop bits, back-to-back words
    baud_tick_max = 14'd15; parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1;
    loop = 1'b1;
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tx_data = words[i]; tx_valid = 1'b1;
      exp_q.push_back({2'b00, words[i]});
      @(posedge clk);
    end
    @(negedge clk) tx_valid = 1'b0;
    @(posedge clk);
    #1;
    count_run(1'b1, run);
    count_run(1'b0, lo1);
    count_run(1'b1, hi);
    count_run(1'b0, lo2);
    check("b2b_idle_1", lo1, 1);
    check("frame_len", hi, 192);
    check("b2b_idle_2", lo2, 1);
    wait_drain("loop_drain", 600);
    loop = 1'b0; rx_drv = 1'b1;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (5) @(posedge clk);

    // Overrun: five frames into a four-deep rx FIFO with no pops
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = DB'((i + 1) * 17);
      if (i == 4) check("ovr_before_5th", rx_overrun, 0);
      if (exp_q.size() < FD) exp_q.push_back({2'b00, d});
      send_rx(d, 1'b0, 1'b1, 15);
      rx_drv = 1'b1;
      repeat (3) @(posedge clk);
    end
    #1;
    check("ovr_set", rx_overrun, 1);
    check("ovr_head", rx_data, 8'h11);
    check("ovr_held", exp_q.size(), FD);
    @(negedge clk) clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    check("ovr_clr", rx_overrun, 0);
    @(negedge clk) rx_ready = 1'b1;
    wait_drain("ovr_drain", 20);

    // Stop bit 0 with bad even parity, then line held low
    parity_en = 1'b1; parity_odd = 1'b0;
    exp_q.push_back({2'b11, 8'h5A});
    send_rx(8'h5A, 1'b1, 1'b0, 15);
    repeat (80) @(posedge clk);
    #1 check("brk_no_word", rx_valid, 0);
    check("brk_sb", exp_q.size(), 0);
    rx_drv = 1'b1;
    repeat (5) @(posedge clk);
    exp_q.push_back({2'b00, 8'h3C});
    send_rx(8'h3C, 1'b0, 1'b1, 15);
    rx_drv = 1'b1;
    wait_drain("brk_recover", 40);

    // 4-clock glitch, then a valid frame
    parity_en = 1'b0;
    repeat (5) @(posedge clk);
    rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("glitch_no_word", rx_valid, 0);
    exp_q.push_back({2'b00, 8'hC3});
    send_rx(8'hC3, 1'b0, 1'b1, 15);
    rx_drv = 1'b1;
    wait_drain("glitch_recover", 40);

    // Reset mid-frame with words still queued
    baud_tick_max = 14'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tx_data = DB'(i + 1); tx_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk) tx_valid = 1'b0;
    repeat (30) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("mrst_tx", tx, 1);
    check("mrst_tx_ready", tx_ready, 1);
    check("mrst_tx_busy", tx_busy, 0);
    check("mrst_rx_valid", rx_valid, 0);
    @(negedge clk) reset = 1'b1;
    saw_low = 1'b0;
    repeat (200) begin
      @(posedge clk);
      #1 if (!tx || tx_busy) saw_low = 1'b1;
    end
    check("mrst_stays_idle", saw_low, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
